load_hazard_unit: RTL and testbench

- Parametrised load-use hazard detector for a RISC-V pipeline whose data memory returns load data after LOAD_LATENCY cycles.
- Tracks in-flight loads in a small shift scoreboard.
- Stalls the ID-stage instruction until its source operand is forwardable, and injects bubbles into ID/EX.
- Sits beside the forwarding unit. Drives PC/IF-ID freeze and the ID/EX bubble.

---
 rtl/load_hazard_unit.sv | 111 +++++++++++
 tb/tb_load_hazard_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_hazard_unit.sv
// Load-use hazard detector with a shift scoreboard of loads still inside the data-memory latency window.
// Optional stall-cycle counter enabled by defining LOAD_HAZARD_STALL_CNT_EN.
module load_hazard_unit #(
    parameter int REG_W        = 5,
    parameter int LOAD_LATENCY = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_kill,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             mem_stall,
    output logic             stall,
    output logic             flush,
    output logic [3:0]       hazard_age,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int DEPTH = (LOAD_LATENCY > 1) ? LOAD_LATENCY - 1 : 1;

    function automatic logic src_hit(
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2,
        input logic             use1,
        input logic             use2
    );
        return (use1 && rs1 == rd) || (use2 && rs2 == rd);
    endfunction

    logic             ex_match;
    logic [DEPTH:1]   pend_match;
    logic [3:0]       age_raw;
    logic             hazard;

    assign ex_match = ex_is_load && (ex_rd != '0)
                    && src_hit(ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);

    generate
        if (LOAD_LATENCY > 1) begin : g_sb
            logic [DEPTH:1]   pend_valid;
            logic [REG_W-1:0] pend_rd [1:DEPTH];

            // The scoreboard advances with the pipeline, independent of our own stall/flush.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_valid <= '0;
                end else if (!mem_stall) begin
                    pend_valid[1] <= ex_is_load && (ex_rd != '0);
                    for (int k = 2; k <= DEPTH; k++) begin
                        pend_valid[k] <= pend_valid[k-1];
                    end
                end
            end

            // NOTE: register indices are qualified by pend_valid, so they need no reset.
            always_ff @(posedge clk) begin
                if (!mem_stall) begin
                    pend_rd[1] <= ex_rd;
                    for (int k = 2; k <= DEPTH; k++) begin
                        pend_rd[k] <= pend_rd[k-1];
                    end
                end
            end

            for (genvar k = 1; k <= DEPTH; k++) begin : g_match
                assign pend_match[k] = pend_valid[k]
                    && src_hit(pend_rd[k], id_rs1, id_rs2, id_use_rs1, id_use_rs2);
            end
        end else begin : g_no_sb
            assign pend_match = '0;
        end
    endgenerate

    // NOTE: default first so every path assigns age_raw and no latch is inferred.
    always_comb begin
        age_raw = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (pend_match[k]) age_raw = 4'(k + 1);
        end
        if (ex_match) age_raw = 4'd1;
    end

    // NOTE: the EX comparison is purely combinational, so reset must gate it explicitly.
    assign hazard     = (ex_match || (|pend_match)) && !id_kill && rst_n;
    assign stall      = hazard;
    assign flush      = hazard && !mem_stall;
    assign hazard_age = hazard ? age_raw : 4'd0;

`ifdef LOAD_HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall && !mem_stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_load_hazard_unit.sv
// Self-checking bench: three latencies driven in parallel, compared each cycle against a load-history model.
// Counter expectations follow LOAD_HAZARD_STALL_CNT_EN.
module tb_load_hazard_unit;

`ifdef LOAD_HAZARD_STALL_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, id_kill, ex_is_load, mem_stall;

    logic [3:1]        stall_o;
    logic [3:1]        flush_o;
    logic [3:1][3:0]   age_o;
    logic [3:1][31:0]  cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_hazard_unit #(.REG_W(5), .LOAD_LATENCY(1), .CNT_W(32)) u_ll1 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_kill(id_kill),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_stall(mem_stall),
        .stall(stall_o[1]), .flush(flush_o[1]), .hazard_age(age_o[1]), .stall_cycles(cnt_o[1])
    );

    load_hazard_unit #(.REG_W(5), .LOAD_LATENCY(2), .CNT_W(32)) u_ll2 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_kill(id_kill),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_stall(mem_stall),
        .stall(stall_o[2]), .flush(flush_o[2]), .hazard_age(age_o[2]), .stall_cycles(cnt_o[2])
    );

    load_hazard_unit #(.REG_W(5), .LOAD_LATENCY(3), .CNT_W(32)) u_ll3 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_kill(id_kill),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_stall(mem_stall),
        .stall(stall_o[3]), .flush(flush_o[3]), .hazard_age(age_o[3]), .stall_cycles(cnt_o[3])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of destination registers that left EX on each unfrozen edge (0 = no load).
    logic [4:0]  hist [$];
    int unsigned exp_cnt [1:3];

    function automatic logic uses(input logic [4:0] rd);
        return (id_use_rs1 && id_rs1 == rd) || (id_use_rs2 && id_rs2 == rd);
    endfunction

    function automatic int exp_age(input int ll);
        if (!rst_n || id_kill) return 0;
        if (ex_is_load && ex_rd != 5'd0 && uses(ex_rd)) return 1;
        for (int j = 0; j < ll - 1 && j < hist.size(); j++) begin
            if (hist[j] != 5'd0 && uses(hist[j])) return j + 2;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            for (int l = 1; l <= 3; l++) exp_cnt[l] = 0;
        end else if (!mem_stall) begin
            if (CNT_ON != 0) begin
                for (int l = 1; l <= 3; l++) if (exp_age(l) != 0) exp_cnt[l]++;
            end
            hist.push_front(ex_is_load ? ex_rd : 5'd0);
            if (hist.size() > 8) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        for (int l = 1; l <= 3; l++) begin
            int a;
            a = exp_age(l);
            check($sformatf("ll%0d_stall", l), 32'(stall_o[l]), 32'(a != 0));
            check($sformatf("ll%0d_flush", l), 32'(flush_o[l]), 32'(a != 0 && !mem_stall));
            check($sformatf("ll%0d_age", l), 32'(age_o[l]), 32'(a));
            check($sformatf("ll%0d_cnt", l), cnt_o[l], 32'(exp_cnt[l]));
        end
    end

    task automatic set_in(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic u1, input logic [4:0] rs2, input logic u2,
                          input logic kill, input logic ms);
        ex_is_load = ld;  ex_rd = rd;
        id_rs1 = rs1;     id_use_rs1 = u1;
        id_rs2 = rs2;     id_use_rs2 = u2;
        id_kill = kill;   mem_stall = ms;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drain();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) next();
    endtask

    initial begin
        rst_n = 1'b0;
        // Matching load during reset must not stall.
        set_in(1, 5, 5, 1, 0, 0, 0, 0);
        settle();
        check("rst_stall_ll2", 32'(stall_o[2]), 0);
        check("rst_flush_ll2", 32'(flush_o[2]), 0);
        check("rst_age_ll2", 32'(age_o[2]), 0);
        next();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        next();

        // Dependent directly behind lw x5.
        set_in(1, 5, 5, 1, 0, 0, 0, 0);
        settle();
        check("dep_c0_ll2_age", 32'(age_o[2]), 1);
        check("dep_c0_ll2_flush", 32'(flush_o[2]), 1);
        check("dep_c0_ll1_age", 32'(age_o[1]), 1);
        next();
        set_in(0, 0, 5, 1, 0, 0, 0, 0);
        settle();
        check("dep_c1_ll2_age", 32'(age_o[2]), 2);
        check("dep_c1_ll1_stall", 32'(stall_o[1]), 0);
        next();
        settle();
        check("dep_c2_ll2_stall", 32'(stall_o[2]), 0);
        check("dep_c2_ll3_age", 32'(age_o[3]), 3);
        check("dep_cnt_ll2", cnt_o[2], 32'(2 * CNT_ON));
        check("dep_cnt_ll1", cnt_o[1], 32'(1 * CNT_ON));
        next();
        settle();
        check("dep_c3_ll3_stall", 32'(stall_o[3]), 0);
        check("dep_cnt_ll3", cnt_o[3], 32'(3 * CNT_ON));
        drain();

        // Consumer one instruction behind the load.
        set_in(1, 6, 1, 1, 0, 0, 0, 0);
        next();
        set_in(0, 0, 6, 1, 0, 0, 0, 0);
        settle();
        check("behind_ll1_stall", 32'(stall_o[1]), 0);
        check("behind_ll2_age", 32'(age_o[2]), 2);
        drain();

        // Load to x0 and unused source register.
        set_in(1, 0, 0, 1, 0, 1, 0, 0);
        settle();
        check("x0_ex_ll3_stall", 32'(stall_o[3]), 0);
        next();
        set_in(0, 0, 0, 1, 0, 1, 0, 0);
        settle();
        check("x0_pend_ll3_stall", 32'(stall_o[3]), 0);
        next();
        set_in(1, 5, 5, 0, 0, 0, 0, 0);
        settle();
        check("unused_ll2_stall", 32'(stall_o[2]), 0);
        drain();

        // Freeze for three cycles while the hazard is active.
        set_in(1, 5, 5, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("frz_ll2_stall", 32'(stall_o[2]), 1);
            check("frz_ll2_flush", 32'(flush_o[2]), 0);
            next();
        end
        set_in(1, 5, 5, 1, 0, 0, 0, 0);
        settle();
        check("rel0_ll2_flush", 32'(flush_o[2]), 1);
        next();
        set_in(0, 0, 5, 1, 0, 0, 0, 0);
        settle();
        check("rel1_ll2_age", 32'(age_o[2]), 2);
        check("rel1_ll2_flush", 32'(flush_o[2]), 1);
        next();
        settle();
        check("rel2_ll2_stall", 32'(stall_o[2]), 0);
        drain();

        // Kill suppresses the hazard but the load still advances.
        set_in(1, 5, 5, 1, 0, 0, 1, 0);
        settle();
        check("kill_ll2_stall", 32'(stall_o[2]), 0);
        check("kill_ll2_flush", 32'(flush_o[2]), 0);
        next();
        set_in(0, 0, 5, 1, 0, 0, 0, 0);
        settle();
        check("kill_next_ll2_age", 32'(age_o[2]), 2);
        next();
        settle();
        check("kill_retire_ll2_stall", 32'(stall_o[2]), 0);
        drain();

        // Back-to-back loads hit by rs1 and rs2.
        set_in(1, 3, 0, 0, 0, 0, 0, 0);
        next();
        set_in(1, 4, 3, 1, 4, 1, 0, 0);
        settle();
        check("b2b_c0_ll2_age", 32'(age_o[2]), 1);
        next();
        set_in(0, 0, 3, 1, 4, 1, 0, 0);
        settle();
        check("b2b_c1_ll2_age", 32'(age_o[2]), 2);
        check("b2b_c1_ll3_age", 32'(age_o[3]), 2);
        next();
        settle();
        check("b2b_c2_ll2_stall", 32'(stall_o[2]), 0);
        check("b2b_c2_ll3_age", 32'(age_o[3]), 3);
        drain();

        // Reset pulsed mid-stall.
        set_in(1, 7, 7, 1, 0, 0, 0, 0);
        settle();
        check("pre_rst_ll2_stall", 32'(stall_o[2]), 1);
        next();
        set_in(0, 0, 7, 1, 0, 0, 0, 0);
        settle();
        check("pre_rst_ll2_age", 32'(age_o[2]), 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ll2_stall", 32'(stall_o[2]), 0);
        check("midrst_ll3_flush", 32'(flush_o[3]), 0);
        check("midrst_ll3_age", 32'(age_o[3]), 0);
        check("midrst_ll2_cnt", cnt_o[2], 0);
        next();
        rst_n = 1'b1;
        settle();
        check("postrst_ll2_stall", 32'(stall_o[2]), 0);
        check("postrst_ll3_stall", 32'(stall_o[3]), 0);
        next();
        settle();
        check("postrst_ll3_cnt", cnt_o[3], 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
